// File: rtl/wb_pkg.sv
// Write-back stage shared definitions.
//   - wb_sel_e    : write-back source select encodings
//   - mem_size_e  : load access size encodings
//   - sel_is_legal: true for the defined select codes (000..100)
package wb_pkg;

   typedef enum logic [2:0] {
      WB_SEL_MEM     = 3'b000,
      WB_SEL_ALU     = 3'b001,
      WB_SEL_PC_IMM  = 3'b010,
      WB_SEL_IMM     = 3'b011,
      WB_SEL_NEXT_PC = 3'b100
   } wb_sel_e;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } mem_size_e;

   // Codes 101..111 are unassigned.
   function automatic logic sel_is_legal(input logic [2:0] sel);
      return (sel <= WB_SEL_NEXT_PC);
   endfunction

endpackage

// File: rtl/wb_stage_load_extend.sv
// Combinational load-data extractor.
// Picks the addressed byte/half/word lane out of an aligned memory word and
// sign- or zero-extends it to XLEN.
// Ports:
//   i_raw      XLEN        aligned memory word
//   i_offset   log2(XLEN/8) byte offset of the load address
//   i_size     2           00 byte, 01 half, 10 word, 11 dword (word when XLEN=32)
//   i_unsigned 1           zero-extend when 1
//   o_result   XLEN        extended load value
module load_extend
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]           i_raw,
   input  logic [$clog2(XLEN/8)-1:0] i_offset,
   input  logic [1:0]                i_size,
   input  logic                      i_unsigned,
   output logic [XLEN-1:0]           o_result
);

   localparam int OFF_W = $clog2(XLEN/8);

   logic [OFF_W-1:0] lane;
   logic [OFF_W+2:0] shamt;
   logic [6:0]       nbits;
   logic [XLEN-1:0]  shifted;
   logic [XLEN-1:0]  keep_mask;
   logic [XLEN-1:0]  sign_pos;
   logic             sign;

   // Lane is the offset with the bits below the access size cleared. For
   // XLEN=32 the word mask clears every offset bit, so size 11 degenerates
   // to a plain word access with no further special casing.
   always_comb begin
      lane  = '0;
      nbits = 7'(XLEN);
      case (i_size)
         SZ_B: begin
            lane  = i_offset;
            nbits = 7'd8;
         end
         SZ_H: begin
            lane  = i_offset & ({OFF_W{1'b1}} << 1);
            nbits = 7'd16;
         end
         SZ_W: begin
            lane  = i_offset & ({OFF_W{1'b1}} << 2);
            nbits = 7'd32;
         end
         default: begin
            lane  = '0;
            nbits = 7'(XLEN);
         end
      endcase
   end

   assign shamt     = {lane, 3'b000};
   assign shifted   = i_raw >> shamt;
   // Shifting by nbits == XLEN yields zero, so a full-width access keeps all bits.
   assign keep_mask = ~({XLEN{1'b1}} << nbits);
   assign sign_pos  = {{(XLEN-1){1'b0}}, 1'b1} << (nbits - 7'd1);
   assign sign      = ~i_unsigned & (|(shifted & sign_pos));
   assign o_result  = (shifted & keep_mask) | ({XLEN{sign}} & ~keep_mask);

endmodule

// File: rtl/wb_stage.sv
// Registered write-back stage between the memory stage and the register file.
// Captures MEM/WB operands, extends load data, selects the write-back source
// and presents a registered register-file write port plus a retire counter.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid/i_stall/i_flush  pipeline control (priority rst > flush > stall)
//   i_reg_wr_sel          source select (mem, alu, pc+imm, imm, next-pc)
//   i_reg_wr_en, i_rd_addr  destination write request
//   i_alu_result, i_mem_rdata, i_mem_offset, i_mem_size, i_mem_unsigned,
//   i_pc_immed, i_immed, i_next_pc_addr   source operands
//   o_valid, o_rd_wen, o_rd_addr, o_wr_back_data   registered write port
//   o_illegal_sel         captured select was undefined
//   o_retire_count        retired-instruction count (wraps)
module wb_stage
   import wb_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_valid,
   input  logic                      i_stall,
   input  logic                      i_flush,
   input  logic [2:0]                i_reg_wr_sel,
   input  logic                      i_reg_wr_en,
   input  logic [REG_AW-1:0]         i_rd_addr,
   input  logic [XLEN-1:0]           i_alu_result,
   input  logic [XLEN-1:0]           i_mem_rdata,
   input  logic [$clog2(XLEN/8)-1:0] i_mem_offset,
   input  logic [1:0]                i_mem_size,
   input  logic                      i_mem_unsigned,
   input  logic [XLEN-1:0]           i_pc_immed,
   input  logic [XLEN-1:0]           i_immed,
   input  logic [XLEN-1:0]           i_next_pc_addr,
   output logic                      o_valid,
   output logic                      o_rd_wen,
   output logic [REG_AW-1:0]         o_rd_addr,
   output logic [XLEN-1:0]           o_wr_back_data,
   output logic                      o_illegal_sel,
   output logic [CNT_W-1:0]          o_retire_count
);

   logic              valid_q,   valid_d;
   logic              rd_wen_q,  rd_wen_d;
   logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
   logic [XLEN-1:0]   wb_data_q, wb_data_d;
   logic              illegal_q, illegal_d;
   logic [CNT_W-1:0]  retire_q,  retire_d;

   logic              sel_legal;
   logic [XLEN-1:0]   load_data;
   logic [XLEN-1:0]   src_data;

   load_extend #(
      .XLEN (XLEN)
   ) u_load_extend (
      .i_raw      (i_mem_rdata),
      .i_offset   (i_mem_offset),
      .i_size     (i_mem_size),
      .i_unsigned (i_mem_unsigned),
      .o_result   (load_data)
   );

   assign sel_legal = sel_is_legal(i_reg_wr_sel);

   always_comb begin
      src_data = '0;
      case (i_reg_wr_sel)
         WB_SEL_MEM:     src_data = load_data;
         WB_SEL_ALU:     src_data = i_alu_result;
         WB_SEL_PC_IMM:  src_data = i_pc_immed;
         WB_SEL_IMM:     src_data = i_immed;
         WB_SEL_NEXT_PC: src_data = i_next_pc_addr;
         default:        src_data = '0;
      endcase
   end

   // Flush beats stall. A flushed slot keeps the old data/addr (don't-care)
   // but drops valid, write enable and the illegal flag.
   always_comb begin
      valid_d   = valid_q;
      rd_wen_d  = rd_wen_q;
      rd_addr_d = rd_addr_q;
      wb_data_d = wb_data_q;
      illegal_d = illegal_q;
      retire_d  = retire_q;
      if (i_flush) begin
         valid_d   = 1'b0;
         rd_wen_d  = 1'b0;
         illegal_d = 1'b0;
      end else if (!i_stall) begin
         valid_d   = i_valid;
         rd_addr_d = i_rd_addr;
         rd_wen_d  = i_valid & i_reg_wr_en & (i_rd_addr != '0) & sel_legal;
         illegal_d = i_valid & ~sel_legal;
         wb_data_d = src_data;
         // Counts every retired instruction, including ones that never write rd.
         if (i_valid) begin
            retire_d = retire_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q   <= 1'b0;
         rd_wen_q  <= 1'b0;
         rd_addr_q <= '0;
         wb_data_q <= '0;
         illegal_q <= 1'b0;
         retire_q  <= '0;
      end else begin
         valid_q   <= valid_d;
         rd_wen_q  <= rd_wen_d;
         rd_addr_q <= rd_addr_d;
         wb_data_q <= wb_data_d;
         illegal_q <= illegal_d;
         retire_q  <= retire_d;
      end
   end

   assign o_valid        = valid_q;
   assign o_rd_wen       = rd_wen_q;
   assign o_rd_addr      = rd_addr_q;
   assign o_wr_back_data = wb_data_q;
   assign o_illegal_sel  = illegal_q;
   assign o_retire_count = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage (XLEN=32, CNT_W=4 so the counter wraps quickly).
// Each driven cycle pushes the expected registered outputs onto a scoreboard
// queue; the entry is popped and compared one edge later.
module tb_wb_stage;
   import wb_pkg::*;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst, valid, stall, flush, wen, uns;
   logic [2:0]        sel;
   logic [REG_AW-1:0] rd;
   logic [XLEN-1:0]   alu, mem, pcimm, imm, npc;
   logic [1:0]        off;
   logic [1:0]        size;

   logic              o_valid, o_rd_wen, o_illegal_sel;
   logic [REG_AW-1:0] o_rd_addr;
   logic [XLEN-1:0]   o_wr_back_data;
   logic [CNT_W-1:0]  o_retire_count;

   always #5 clk = ~clk;

   wb_stage #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW),
      .CNT_W  (CNT_W)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_valid        (valid),
      .i_stall        (stall),
      .i_flush        (flush),
      .i_reg_wr_sel   (sel),
      .i_reg_wr_en    (wen),
      .i_rd_addr      (rd),
      .i_alu_result   (alu),
      .i_mem_rdata    (mem),
      .i_mem_offset   (off),
      .i_mem_size     (size),
      .i_mem_unsigned (uns),
      .i_pc_immed     (pcimm),
      .i_immed        (imm),
      .i_next_pc_addr (npc),
      .o_valid        (o_valid),
      .o_rd_wen       (o_rd_wen),
      .o_rd_addr      (o_rd_addr),
      .o_wr_back_data (o_wr_back_data),
      .o_illegal_sel  (o_illegal_sel),
      .o_retire_count (o_retire_count)
   );

   typedef struct packed {
      logic              valid;
      logic              wen;
      logic [REG_AW-1:0] addr;
      logic [XLEN-1:0]   data;
      logic              ill;
      logic [CNT_W-1:0]  cnt;
   } exp_t;

   exp_t sb_q[$];
   exp_t m;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Byte-by-byte reference for load extraction.
   function automatic logic [XLEN-1:0] ref_load(input logic [XLEN-1:0] raw, input logic [1:0] o,
                                                input logic [1:0] sz, input logic u);
      int nbytes;
      int base;
      logic [XLEN-1:0] r;
      r = '0;
      case (sz)
         2'b00:   begin nbytes = 1; base = int'(o); end
         2'b01:   begin nbytes = 2; base = int'(o) & 2; end
         default: begin nbytes = 4; base = 0; end
      endcase
      for (int i = 0; i < nbytes * 8; i++) r[i] = raw[base * 8 + i];
      if (!u) begin
         for (int i = nbytes * 8; i < XLEN; i++) r[i] = r[nbytes * 8 - 1];
      end
      return r;
   endfunction

   // Inputs already applied (after a negedge): update the model, push, clock, compare.
   task automatic step();
      exp_t e;
      logic legal;
      if (rst) begin
         m = '0;
      end else if (flush) begin
         m.valid = 1'b0;
         m.wen   = 1'b0;
         m.ill   = 1'b0;
      end else if (!stall) begin
         legal   = (sel <= 3'd4);
         m.valid = valid;
         m.addr  = rd;
         m.wen   = valid & wen & (rd != 0) & legal;
         m.ill   = valid & ~legal;
         case (sel)
            3'd0:    m.data = ref_load(mem, off, size, uns);
            3'd1:    m.data = alu;
            3'd2:    m.data = pcimm;
            3'd3:    m.data = imm;
            3'd4:    m.data = npc;
            default: m.data = '0;
         endcase
         if (valid) m.cnt = m.cnt + 1'b1;
      end
      sb_q.push_back(m);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check_eq("sb_empty", 64'd0, 64'd1);
      end else begin
         e = sb_q.pop_front();
         check_eq("valid", 64'(o_valid),        64'(e.valid));
         check_eq("wen",   64'(o_rd_wen),       64'(e.wen));
         check_eq("addr",  64'(o_rd_addr),      64'(e.addr));
         check_eq("data",  64'(o_wr_back_data), 64'(e.data));
         check_eq("ill",   64'(o_illegal_sel),  64'(e.ill));
         check_eq("cnt",   64'(o_retire_count), 64'(e.cnt));
      end
   endtask

   task automatic set_op(input logic v, input logic [2:0] s, input logic w, input logic [REG_AW-1:0] r);
      @(negedge clk);
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      valid = v; sel = s; wen = w; rd = r;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      m = '0;
      rst = 1'b1; valid = 1'b0; stall = 1'b0; flush = 1'b0; wen = 1'b0; uns = 1'b0;
      sel = 3'd0; rd = '0; alu = '0; mem = '0; pcimm = '0; imm = '0; npc = '0;
      off = '0; size = '0;

      // Reset for two cycles.
      @(negedge clk); rst = 1'b1; step();
      @(negedge clk); rst = 1'b1; valid = 1'b1; stall = 1'b1; step();
      check_eq("rst_valid", 64'(o_valid), 64'd0);
      check_eq("rst_cnt",   64'(o_retire_count), 64'd0);

      // First ALU capture.
      set_op(1'b1, 3'b001, 1'b1, 5'd5); alu = 32'h1234_5678; step();
      check_eq("alu_data", 64'(o_wr_back_data), 64'h1234_5678);
      check_eq("alu_cnt",  64'(o_retire_count), 64'd1);
      check_eq("alu_wen",  64'(o_rd_wen), 64'd1);

      // Load extension vectors.
      mem = 32'h80FF_7F01;
      set_op(1'b1, 3'b000, 1'b1, 5'd9); size = 2'b00; off = 2'd2; uns = 1'b0; step();
      check_eq("lb_off2_s", 64'(o_wr_back_data), 64'hFFFF_FFFF);
      set_op(1'b1, 3'b000, 1'b1, 5'd9); size = 2'b00; off = 2'd2; uns = 1'b1; step();
      check_eq("lb_off2_u", 64'(o_wr_back_data), 64'h0000_00FF);
      set_op(1'b1, 3'b000, 1'b1, 5'd9); size = 2'b01; off = 2'd2; uns = 1'b0; step();
      check_eq("lh_off2_s", 64'(o_wr_back_data), 64'hFFFF_80FF);
      set_op(1'b1, 3'b000, 1'b1, 5'd9); size = 2'b01; off = 2'd1; uns = 1'b1; step();
      check_eq("lh_off1_u", 64'(o_wr_back_data), 64'h0000_7F01);
      set_op(1'b1, 3'b000, 1'b1, 5'd9); size = 2'b11; off = 2'd3; uns = 1'b0; step();
      check_eq("ld_x32_w", 64'(o_wr_back_data), 64'h80FF_7F01);

      // rd = 0 and illegal select.
      set_op(1'b1, 3'b001, 1'b1, 5'd0); step();
      check_eq("rd0_wen", 64'(o_rd_wen), 64'd0);
      set_op(1'b1, 3'b110, 1'b1, 5'd3); step();
      check_eq("ill_flag", 64'(o_illegal_sel), 64'd1);
      check_eq("ill_data", 64'(o_wr_back_data), 64'd0);
      set_op(1'b1, 3'b011, 1'b1, 5'd4); imm = 32'hCAFE_0001; step();
      check_eq("ill_clear", 64'(o_illegal_sel), 64'd0);

      // Stall holds, then stall+flush.
      set_op(1'b1, 3'b100, 1'b1, 5'd7); npc = 32'h0000_0100; step();
      for (int i = 0; i < 3; i++) begin
         set_op(1'b1, 3'b001, 1'b1, 5'(10 + i)); stall = 1'b1;
         alu = 32'hDEAD_0000 + 32'(i); step();
         check_eq("stall_data", 64'(o_wr_back_data), 64'h100);
      end
      set_op(1'b1, 3'b001, 1'b1, 5'd12); stall = 1'b1; flush = 1'b1; step();
      check_eq("sf_valid", 64'(o_valid), 64'd0);
      check_eq("sf_wen",   64'(o_rd_wen), 64'd0);

      // Random traffic.
      for (int i = 0; i < 80; i++) begin
         set_op(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                1'($urandom), 5'($urandom));
         stall = ($urandom_range(0, 5) == 0);
         flush = ($urandom_range(0, 7) == 0);
         alu = $urandom; mem = $urandom; pcimm = $urandom; imm = $urandom; npc = $urandom;
         off = 2'($urandom); size = 2'($urandom); uns = 1'($urandom);
         step();
      end

      // Reset while stalled with valid output.
      set_op(1'b1, 3'b001, 1'b1, 5'd6); alu = 32'h5555_AAAA; step();
      set_op(1'b1, 3'b001, 1'b1, 5'd8); stall = 1'b1; step();
      check_eq("pre_rst_valid", 64'(o_valid), 64'd1);
      set_op(1'b1, 3'b001, 1'b1, 5'd8); stall = 1'b1; rst = 1'b1; step();
      check_eq("mid_rst_valid", 64'(o_valid), 64'd0);
      check_eq("mid_rst_data",  64'(o_wr_back_data), 64'd0);
      check_eq("mid_rst_cnt",   64'(o_retire_count), 64'd0);

      // Counter wrap: 17 captures on a 4-bit counter.
      for (int i = 0; i < 17; i++) begin
         set_op(1'b1, 3'b001, 1'b0, 5'd1); alu = 32'(i); step();
      end
      check_eq("wrap_cnt", 64'(o_retire_count), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Registered, parametrised write-back stage. Sits between the memory stage and the register file.
- Captures the MEM/WB operands, then extracts and sign- or zero-extends load data by size and byte offset.
- Selects the write-back source and presents a registered register-file write port with valid, stall and flush control.
- Adds a retired-instruction counter and an illegal-select flag.

Parameters:
- XLEN, 32, datapath width. Must be 32 or 64.
- REG_AW, 5, register-address width.
- CNT_W, 32, retire-counter width.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  upstream instruction valid
- i_stall  in  1  hold the WB register contents
- i_flush  in  1  kill the instruction being captured this cycle
- i_reg_wr_sel  in  3  source select: 000 mem, 001 alu, 010 pc+imm, 011 imm, 100 next-pc
- i_reg_wr_en  in  1  instruction writes rd
- i_rd_addr  in  REG_AW  destination register
- i_alu_result  in  XLEN  ALU result
- i_mem_rdata  in  XLEN  raw aligned memory word
- i_mem_offset  in  log2(XLEN/8)  byte offset of the load address
- i_mem_size  in  2  00 byte, 01 half, 10 word, 11 dword (dword only when XLEN=64)
- i_mem_unsigned  in  1  zero-extend when 1
- i_pc_immed  in  XLEN  pc+imm
- i_immed  in  XLEN  immediate
- i_next_pc_addr  in  XLEN  pc+4
- o_valid  out  1  registered valid
- o_rd_wen  out  1  register-file write enable
- o_rd_addr  out  REG_AW  register-file write address
- o_wr_back_data  out  XLEN  register-file write data
- o_illegal_sel  out  1  registered flag: captured select was undefined
- o_retire_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset (sync, i_rst=1 at edge): all outputs 0, counter 0. Reset overrides stall and flush.
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Capture rule at each edge, in priority order:
  - rst
  - flush: o_valid<=0, o_rd_wen<=0, data/addr don't-care (hold)
  - stall: hold every output
  - otherwise: capture
- On capture:
  - o_valid <= i_valid
  - o_rd_addr <= i_rd_addr
  - o_rd_wen <= i_valid & i_reg_wr_en & (i_rd_addr != 0) & sel_legal
  - o_illegal_sel <= i_valid & !sel_legal
  - o_wr_back_data <= selected source
- Undefined select codes (101, 110, 111): data 0, wen forced 0, o_illegal_sel=1 for that one registered cycle.
- Load extraction (sel 000):
  - Byte lane = i_mem_offset.
  - Half uses offset with LSB ignored (offset[0] forced 0).
  - Word (XLEN=64) uses offset[2]. Dword ignores the offset.
  - Result is extended to XLEN: sign-extended from its MSB unless i_mem_unsigned=1.
  - size=11 with XLEN=32 is treated as word.
- Retire counter: increments on every edge where a capture occurs with i_valid=1 and no flush.
  - Not gated by o_rd_wen, so stores and branches count.
  - Wraps modulo 2^CNT_W with no saturation.
- Simultaneous flush+stall: flush wins.
- Stall with i_valid=1: the instruction is not counted until the cycle it is actually captured.
- Outputs are purely registered, with no combinational path from inputs to outputs.

Decomposition:
- Package wb_pkg holds:
  - select encodings: WB_SEL_MEM, WB_SEL_ALU, WB_SEL_PC_IMM, WB_SEL_IMM, WB_SEL_NEXT_PC
  - size encodings: SZ_B, SZ_H, SZ_W, SZ_D
  - function sel_is_legal()
- One combinational sub-module, load_extend (XLEN param): raw word, offset, size, unsigned -> extended value.
- Mux, pipeline register and counter stay in wb_stage.

Test Plan:
- Reset/select: hold rst 2 cycles, then capture sel=001, alu=0x1234_5678, rd=5, wen=1 -> next cycle o_valid=1, o_rd_wen=1, o_rd_addr=5, data=0x1234_5678, retire=1.
- Load extension: mem_rdata=0x80FF_7F01, byte, offset 2, signed -> 0xFFFF_FFFF; same unsigned -> 0x0000_00FF; half offset 2 signed -> 0xFFFF_80FF; half offset 1 unsigned -> 0x0000_7F01.
- rd=0 / illegal select: sel=001, rd=0, wen=1 -> o_rd_wen=0, retire increments. sel=110, rd=3 -> data 0, o_rd_wen=0, o_illegal_sel=1 for one cycle.
- Stall/flush: capture sel=100, next_pc=0x100, then stall 3 cycles with new inputs -> outputs hold 0x100 and retire unchanged. Assert stall+flush together -> o_valid=0, o_rd_wen=0, retire unchanged.
- Counter wrap: CNT_W=4, 17 valid captures -> o_retire_count=1.
- Mid-operation reset: assert rst while stalled with o_valid=1 -> next cycle every output is 0, including the counter.
